// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: hold/load/shift/rotate with a burst controller that repeats a latched shift op N times.
// Single-step ops take effect on the next edge; bursts assert busy while running, then pulse done for one cycle.
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [2:0] lat_mode;
  logic [CNT_W-1:0] cnt;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] m,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] dat,
                                                input logic s);
    logic [WIDTH-1:0] r;
    r = cur;
    case (m)
      M_LOAD:  r = dat;
      M_SHL:   r = {cur[WIDTH-2:0], s};
      M_SHR:   r = {s, cur[WIDTH-1:1]};
      M_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROR:   r = {cur[0], cur[WIDTH-1:1]};
      M_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: r = cur;
    endcase
    return r;
  endfunction

  // Only the shift/rotate family is worth repeating; HOLD/LOAD/reserved complete in one edge.
  function automatic logic is_shift(input logic [2:0] m);
    return (m >= M_SHL) && (m <= M_ASR);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      q        <= '0;
      cnt      <= '0;
      lat_mode <= M_HOLD;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lat_mode <= mode;
            if ((amt != CNT_ZERO) && is_shift(mode)) begin
              state <= BUSY;
              cnt   <= amt;
            end else begin
              q    <= apply_op(mode, q, d, ser_in);
              done <= 1'b1;
            end
          end else if (en) begin
            q <= apply_op(mode, q, d, ser_in);
          end
        end
        BUSY: begin
          q   <= apply_op(lat_mode, q, d, ser_in);
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == BUSY);
  assign qb       = ~q;
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed and randomized checks of shift_reg_univ (WIDTH=8) against an arithmetic reference model.
module tb_shift_reg_univ;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       ser_in;
  logic       start;
  logic [3:0] amt;
  logic [7:0] q;
  logic [7:0] qb;
  logic       sout_msb;
  logic       sout_lsb;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  logic [7:0] exp_q;
  logic       exp_busy;
  logic       exp_done;

  shift_reg_univ #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .ser_in(ser_in),
    .start(start), .amt(amt), .q(q), .qb(qb), .sout_msb(sout_msb),
    .sout_lsb(sout_lsb), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference op computed with integer arithmetic on the 8-bit value.
  function automatic logic [7:0] ref_op(input int m, input int qv, input int dv, input int s);
    int r;
    case (m)
      1:       r = dv;
      2:       r = qv * 2 + s;
      3:       r = qv / 2 + s * 128;
      4:       r = qv * 2 + qv / 128;
      5:       r = qv / 2 + (qv % 2) * 128;
      6:       r = qv / 2 + (qv / 128) * 128;
      default: r = qv;
    endcase
    return 8'(r % 256);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"},    32'(q),        32'(exp_q));
    chk({tag, ".qb"},   32'(qb),       32'(8'(~exp_q)));
    chk({tag, ".msb"},  32'(sout_msb), 32'(exp_q / 128));
    chk({tag, ".lsb"},  32'(sout_lsb), 32'(exp_q % 2));
    chk({tag, ".busy"}, 32'(busy),     32'(exp_busy));
    chk({tag, ".done"}, 32'(done),     32'(exp_done));
  endtask

  task automatic expect_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    exp_q    = eq;
    exp_busy = eb;
    exp_done = ed;
    check_all(tag);
  endtask

  initial begin
    int m;
    int a;
    checks   = 0;
    failures = 0;
    rst = 1'b1; en = 1'b1; mode = 3'd1; d = 8'hFF; ser_in = 1'b0; start = 1'b0; amt = 4'd0;

    // Reset wins over a pending load
    step(); step();
    expect_st("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0; en = 1'b0;
    step();
    expect_st("hold_after_reset", 8'h00, 1'b0, 1'b0);

    en = 1'b1; mode = 3'd1; d = 8'hA5;
    step(); expect_st("load_a5", 8'hA5, 1'b0, 1'b0);
    mode = 3'd2; ser_in = 1'b1;
    step(); expect_st("shl", 8'h4B, 1'b0, 1'b0);
    mode = 3'd3; ser_in = 1'b0;
    step(); expect_st("shr", 8'h25, 1'b0, 1'b0);
    mode = 3'd7;
    step(); expect_st("reserved", 8'h25, 1'b0, 1'b0);

    mode = 3'd1; d = 8'h81;
    step(); expect_st("load_81", 8'h81, 1'b0, 1'b0);
    mode = 3'd4;
    step(); expect_st("rol", 8'h03, 1'b0, 1'b0);
    mode = 3'd5;
    step(); expect_st("ror", 8'h81, 1'b0, 1'b0);
    mode = 3'd6;
    step(); expect_st("asr", 8'hC0, 1'b0, 1'b0);

    // ROL burst of 3 with junk on en/mode/d while busy
    mode = 3'd1; d = 8'h01;
    step(); expect_st("load_01", 8'h01, 1'b0, 1'b0);
    en = 1'b0; start = 1'b1; mode = 3'd4; amt = 4'd3;
    step(); expect_st("burst_e0", 8'h01, 1'b1, 1'b0);
    start = 1'b0; en = 1'b1; mode = 3'd1; d = 8'hFF;
    step(); expect_st("burst_e1", 8'h02, 1'b1, 1'b0);
    mode = 3'd3; amt = 4'd9;
    step(); expect_st("burst_e2", 8'h04, 1'b1, 1'b0);
    en = 1'b0; mode = 3'd0;
    step(); expect_st("burst_e3", 8'h08, 1'b0, 1'b1);
    step(); expect_st("burst_after", 8'h08, 1'b0, 1'b0);

    // amt==0 completes immediately; start while busy is ignored
    start = 1'b1; mode = 3'd0; amt = 4'd0;
    step(); expect_st("amt0", 8'h08, 1'b0, 1'b1);
    mode = 3'd4; amt = 4'd2;
    step(); expect_st("b2_e0", 8'h08, 1'b1, 1'b0);
    mode = 3'd1; d = 8'h00; amt = 4'd0;
    step(); expect_st("b2_e1_start_ignored", 8'h10, 1'b1, 1'b0);
    step(); expect_st("b2_e2", 8'h20, 1'b0, 1'b1);
    start = 1'b0;
    step(); expect_st("b2_after", 8'h20, 1'b0, 1'b0);

    // Reset during a burst aborts it without a done pulse
    en = 1'b1; mode = 3'd1; d = 8'h01;
    step(); expect_st("load_01b", 8'h01, 1'b0, 1'b0);
    en = 1'b0; start = 1'b1; mode = 3'd2; amt = 4'd5; ser_in = 1'b0;
    step(); expect_st("abort_e0", 8'h01, 1'b1, 1'b0);
    start = 1'b0;
    step(); expect_st("abort_e1", 8'h02, 1'b1, 1'b0);
    rst = 1'b1;
    step(); expect_st("abort_rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); expect_st("abort_quiet", 8'h00, 1'b0, 1'b0);
    end

    // Randomized single ops and bursts, including back-to-back starts in the done cycle
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        m = int'($urandom_range(0, 7));
        if (m >= 2 && m <= 6) a = int'($urandom_range(1, 15));
        else a = int'($urandom_range(0, 15));
        start = 1'b1; mode = 3'(m); amt = 4'(a);
        en = 1'($urandom); d = 8'($urandom); ser_in = 1'($urandom);
        step();
        if (m >= 2 && m <= 6) begin
          exp_busy = 1'b1; exp_done = 1'b0;
          check_all("rnd_e0");
          for (int k = 1; k <= a; k++) begin
            start = 1'($urandom); en = 1'($urandom); mode = 3'($urandom);
            d = 8'($urandom); amt = 4'($urandom); ser_in = 1'($urandom);
            step();
            exp_q    = ref_op(m, int'(exp_q), 0, int'(ser_in));
            exp_busy = (k < a);
            exp_done = (k == a);
            check_all("rnd_step");
          end
          start = 1'b0;
        end else begin
          exp_q    = ref_op(m, int'(exp_q), int'(d), int'(ser_in));
          exp_busy = 1'b0;
          exp_done = 1'b1;
          start    = 1'b0;
          check_all("rnd_once");
        end
      end else begin
        start = 1'b0; en = 1'($urandom); mode = 3'($urandom);
        d = 8'($urandom); ser_in = 1'($urandom); amt = 4'($urandom);
        step();
        if (en) exp_q = ref_op(int'(mode), int'(exp_q), int'(d), int'(ser_in));
        exp_busy = 1'b0;
        exp_done = 1'b0;
        check_all("rnd_single");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
